// File: rtl/data_cache_if.sv
// Signal bundle between the CPU MEM stage, the data cache and the backing memory.
// The cache connects through the slave modport; the environment drives through the master modport.
interface data_cache_if #(
  parameter int BLOCK_WORDS = 4
);
  localparam int LINE_W = 32 * BLOCK_WORDS;

  logic              is_input_valid;
  logic [31:0]       addr;
  logic              mem_rw;
  logic [31:0]       din;
  logic              is_ready;
  logic              is_output_valid;
  logic [31:0]       dout;
  logic              is_hit;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  logic [31:0]       hit_count;
  logic [31:0]       miss_count;

  modport master (
    output is_input_valid, addr, mem_rw, din, mem_ack, mem_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );

  modport slave (
    input  is_input_valid, addr, mem_rw, din, mem_ack, mem_rdata,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req, mem_we, mem_addr, mem_wdata, hit_count, miss_count
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one outstanding miss.
// A miss evicts a dirty victim, fills the line, then completes by re-looking up as a hit.
module data_cache #(
  parameter int NUM_LINES   = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic         clk,
  input  logic         reset,
  data_cache_if.slave  bus
);
  localparam int OFF_W   = $clog2(BLOCK_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int IDX_LSB = 2 + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  typedef logic [BLOCK_WORDS-1:0][31:0] line_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  line_t                data_q [NUM_LINES];
  line_t                data_d [NUM_LINES];
  logic [31:0]          hit_count_q, hit_count_d;
  logic [31:0]          miss_count_q, miss_count_d;

  logic [OFF_W-1:0]     req_off;
  logic [IDX_W-1:0]     req_idx;
  logic [TAG_W-1:0]     req_tag;
  line_t                victim_line;
  logic                 lookup_hit;

  assign req_off     = bus.addr[2 +: OFF_W];
  assign req_idx     = bus.addr[IDX_LSB +: IDX_W];
  assign req_tag     = bus.addr[TAG_LSB +: TAG_W];
  assign victim_line = data_q[req_idx];
  assign lookup_hit  = (state_q == IDLE) && bus.is_input_valid &&
                       valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign bus.hit_count  = hit_count_q;
  assign bus.miss_count = miss_count_q;

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    tag_d         = tag_q;
    data_d        = data_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;

    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.is_hit          = 1'b0;
    bus.dout            = '0;
    bus.mem_req         = 1'b0;
    bus.mem_we          = 1'b0;
    bus.mem_addr        = {req_tag, req_idx, {IDX_LSB{1'b0}}};
    bus.mem_wdata       = victim_line;

    unique case (state_q)
      IDLE: begin
        bus.is_ready = 1'b1;
        if (lookup_hit) begin
          bus.is_hit          = 1'b1;
          bus.is_output_valid = 1'b1;
          if (hit_count_q != '1) begin
            hit_count_d = hit_count_q + 32'd1;
          end
          if (bus.mem_rw) begin
            data_d[req_idx][req_off] = bus.din;
            dirty_d[req_idx]         = 1'b1;
          end else begin
            bus.dout = victim_line[req_off];
          end
        end else if (bus.is_input_valid) begin
          if (miss_count_q != '1) begin
            miss_count_d = miss_count_q + 32'd1;
          end
          // Only a dirty victim needs to reach memory before the fill.
          state_d = (valid_q[req_idx] && dirty_q[req_idx]) ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = 1'b1;
        bus.mem_addr = {tag_q[req_idx], req_idx, {IDX_LSB{1'b0}}};
        if (bus.mem_ack) begin
          state_d = ALLOCATE;
        end
      end

      ALLOCATE: begin
        bus.mem_req = 1'b1;
        if (bus.mem_ack) begin
          data_d[req_idx]  = bus.mem_rdata;
          tag_d[req_idx]   = req_tag;
          valid_d[req_idx] = 1'b1;
          dirty_d[req_idx] = 1'b0;
          state_d          = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tag and data storage carry no reset; the valid bits make stale contents harmless.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end
endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios, then random traffic
// checked against a line-level reference model and an associative backing memory.
module tb_data_cache;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  data_cache_if #(.BLOCK_WORDS(4)) bus ();

  data_cache #(.NUM_LINES(16), .BLOCK_WORDS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic         m_valid [16];
  logic         m_dirty [16];
  logic [23:0]  m_tag   [16];
  logic [127:0] m_data  [16];
  logic [127:0] mem_model [logic [31:0]];
  logic [31:0]  exp_hits;
  logic [31:0]  exp_misses;

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_line(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    bus.mem_ack = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_hits   = '0;
    exp_misses = '0;
  endtask

  task automatic mem_read(input logic [31:0] a, output logic [127:0] blk);
    if (!mem_model.exists(a)) begin
      mem_model[a] = {$urandom, $urandom, $urandom, $urandom};
    end
    blk = mem_model[a];
  endtask

  // One memory transaction: delay+1 cycles with mem_ack in the last one.
  task automatic serve_mem(input logic we, input logic [31:0] a, input logic [127:0] wdata,
                           input logic [127:0] rdata, input int delay);
    for (int c = 0; c <= delay; c++) begin
      step();
      if (c == delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end else begin
        bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
      #1;
      check_bit("mem_req_busy", bus.mem_req, 1'b1);
      check_bit("mem_we", bus.mem_we, we);
      check_word("mem_addr", bus.mem_addr, a);
      check_bit("ready_busy", bus.is_ready, 1'b0);
      check_bit("ovalid_busy", bus.is_output_valid, 1'b0);
      if (we) check_line("mem_wdata", bus.mem_wdata, wdata);
    end
  endtask

  task automatic apply_stimulus(input logic [31:0] a, input logic rw, input logic [31:0] wd,
                                input int delay);
    logic [3:0]   idx;
    logic [23:0]  tg;
    int           off;
    logic [127:0] fill;
    logic [31:0]  fill_addr;
    logic [31:0]  wb_addr;
    idx = a[7:4];
    tg  = a[31:8];
    off = int'(a[3:2]);
    step();
    bus.is_input_valid = 1'b1;
    bus.addr           = a;
    bus.mem_rw         = rw;
    bus.din            = wd;
    #1;
    check_bit("ready_idle", bus.is_ready, 1'b1);
    if (!(m_valid[idx] && m_tag[idx] == tg)) begin
      check_bit("miss_hit", bus.is_hit, 1'b0);
      check_bit("miss_ovalid", bus.is_output_valid, 1'b0);
      check_bit("miss_mem_req", bus.mem_req, 1'b0);
      if (exp_misses != 32'hFFFF_FFFF) exp_misses = exp_misses + 32'd1;
      if (m_valid[idx] && m_dirty[idx]) begin
        wb_addr = {m_tag[idx], idx, 4'h0};
        serve_mem(1'b1, wb_addr, m_data[idx], '0, delay);
        mem_model[wb_addr] = m_data[idx];
      end
      fill_addr = {tg, idx, 4'h0};
      mem_read(fill_addr, fill);
      serve_mem(1'b0, fill_addr, '0, fill, delay);
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
      m_tag[idx]   = tg;
      m_data[idx]  = fill;
      step();
      #1;
    end
    check_bit("hit", bus.is_hit, 1'b1);
    check_bit("hit_ovalid", bus.is_output_valid, 1'b1);
    check_bit("hit_ready", bus.is_ready, 1'b1);
    check_bit("hit_mem_req", bus.mem_req, 1'b0);
    if (rw) begin
      m_data[idx][off*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
    end else begin
      check_word("dout", bus.dout, m_data[idx][off*32 +: 32]);
    end
    if (exp_hits != 32'hFFFF_FFFF) exp_hits = exp_hits + 32'd1;
    step();
    bus.is_input_valid = 1'b0;
    bus.addr           = $urandom;
    #1;
    check_bit("idle_ovalid", bus.is_output_valid, 1'b0);
    check_bit("idle_mem_req", bus.mem_req, 1'b0);
    check_word("hit_count", bus.hit_count, exp_hits);
    check_word("miss_count", bus.miss_count, exp_misses);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0]  ra;
    logic [127:0] junk;
    reset              = 1'b0;
    bus.is_input_valid = 1'b0;
    bus.addr           = '0;
    bus.mem_rw         = 1'b0;
    bus.din            = '0;
    bus.mem_ack        = 1'b0;
    bus.mem_rdata      = '0;
    model_reset();

    repeat (2) @(negedge clk);
    #1;
    check_bit("rst_mem_req", bus.mem_req, 1'b0);
    check_bit("rst_ovalid", bus.is_output_valid, 1'b0);
    check_bit("rst_hit", bus.is_hit, 1'b0);
    check_word("rst_dout", bus.dout, 32'h0);
    check_word("rst_hits", bus.hit_count, 32'h0);
    check_word("rst_misses", bus.miss_count, 32'h0);
    step();
    reset = 1'b1;
    #1;
    check_bit("ready_after_reset", bus.is_ready, 1'b1);

    $display("[TB] cold load fill then hit");
    mem_model[32'h100] = {32'hD, 32'hC, 32'hB, 32'hA};
    apply_stimulus(32'h100, 1'b0, 32'h0, 2);
    check_word("cold_hits", bus.hit_count, 32'd1);
    check_word("cold_misses", bus.miss_count, 32'd1);

    $display("[TB] store hit then load back");
    apply_stimulus(32'h104, 1'b1, 32'h1234_5678, 0);
    apply_stimulus(32'h104, 1'b0, 32'h0, 0);

    $display("[TB] dirty victim write-back then fill");
    apply_stimulus(32'h904, 1'b0, 32'h0, 1);
    check_line("wb_block_0x100", mem_model[32'h100],
               {32'hD, 32'hC, 32'h1234_5678, 32'hA});

    $display("[TB] clean victim fill only");
    apply_stimulus(32'hA00, 1'b0, 32'h0, 3);

    $display("[TB] spurious mem_ack in idle");
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    #1;
    check_bit("spur_mem_req", bus.mem_req, 1'b0);
    check_bit("spur_ovalid", bus.is_output_valid, 1'b0);
    step();
    #1;
    check_word("spur_hits", bus.hit_count, exp_hits);
    check_word("spur_misses", bus.miss_count, exp_misses);
    apply_stimulus(32'hA08, 1'b0, 32'h0, 0);

    $display("[TB] reset during allocate");
    step();
    bus.is_input_valid = 1'b1;
    bus.addr           = 32'h100;
    bus.mem_rw         = 1'b0;
    #1;
    check_bit("pre_rst_miss", bus.is_hit, 1'b0);
    step();
    mem_read(32'h100, junk);
    bus.mem_rdata = ~junk;
    #1;
    check_bit("alloc_mem_req", bus.mem_req, 1'b1);
    check_word("alloc_addr", bus.mem_addr, 32'h100);
    #1;
    reset              = 1'b0;
    bus.mem_ack        = 1'b1;
    bus.is_input_valid = 1'b0;
    #1;
    check_bit("midrst_mem_req", bus.mem_req, 1'b0);
    check_bit("midrst_ovalid", bus.is_output_valid, 1'b0);
    check_word("midrst_hits", bus.hit_count, 32'h0);
    check_word("midrst_misses", bus.miss_count, 32'h0);
    model_reset();
    step();
    reset = 1'b1;
    #1;
    check_bit("ready_after_midrst", bus.is_ready, 1'b1);
    apply_stimulus(32'h100, 1'b0, 32'h0, 1);
    check_word("post_rst_misses", bus.miss_count, 32'd1);
    check_word("post_rst_hits", bus.hit_count, 32'd1);

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      ra = {24'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'b00};
      apply_stimulus(ra, 1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
